traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
Parametrised two-road traffic phase controller. It replaces the fixed green/red timing pair with a full six-phase sequence: green, yellow, all-red per road. It adds a pedestrian-request green shortening, a night flash mode, and a countdown output in binary and BCD for the segment display block. It runs on the system clock and has an internal 1-second tick prescaler, so no divided clock domain is needed.

Parameters:
CLK_DIV, 50_000_000, clk cycles per countdown tick (1 s); must be >= 2
T_GX, 30, X-road green duration in ticks; range 1..99
T_GY, 15, Y-road green duration in ticks; range 1..99
T_YEL, 3, yellow duration in ticks; range 1..99
T_AR, 1, all-red clearance duration in ticks; range 1..99
T_PED, 5, green remaining after a pedestrian request; range 1..99
CNT_W, 7, remaining-count width; must hold 99

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ped_req  in  1  pedestrian request pulse or level; any cycle high latches it
flash  in  1  night mode level; high selects flashing yellow
light_x  out  3  X road {R,Y,G}, one-hot or all-zero
light_y  out  3  Y road {R,Y,G}, one-hot or all-zero
remaining  out  CNT_W  ticks left in the current phase; 0 in FLASH
cnt_tens  out  4  BCD tens of remaining
cnt_ones  out  4  BCD ones of remaining
tick  out  1  one-cycle prescaler pulse, for display sync
ped_pend  out  1  pedestrian request latched, not yet served

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state=GX, remaining=T_GX, prescaler=0, tick=0, ped_pend=0, flash_phase=0.
  - Hence light_x=001, light_y=100, cnt_tens/ones=BCD(T_GX).
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick is registered high for exactly one cycle when the count wraps. The first tick occurs CLK_DIV cycles after reset release.
- Phase states and lights (light_x / light_y):
  - GX: 001 / 100
  - YX: 010 / 100
  - AR1: 100 / 100
  - GY: 100 / 001
  - YY: 100 / 010
  - AR2: 100 / 100
  - FLASH: both 0y0, where y=flash_phase
- Sequence: GX -> YX -> AR1 -> GY -> YY -> AR2 -> GX.
- Phase timing:
  - On tick with remaining>1: remaining decrements.
  - On tick with remaining==1: state advances and remaining loads the new phase duration, in the same edge.
  - Lights are decoded from the state register, so they change on the same edge as the state, with no added latency.
- Pedestrian request:
  - ped_pend is set on any cycle with ped_req=1.
  - In GX or GY with ped_pend=1: if remaining>T_PED, remaining<=T_PED; otherwise unchanged. ped_pend clears on that edge in both cases.
  - In any other state, ped_pend holds.
  - Shortening beats a simultaneous tick: remaining loads T_PED and does not decrement that cycle.
  - ped_req in the same cycle as a clear re-sets ped_pend (set wins).
- Flash mode:
  - flash=1 forces state=FLASH on the next edge from any state, with remaining=0. It has priority over ped and tick.
  - In FLASH, flash_phase toggles on each tick. ped_pend holds.
  - flash=0 while in FLASH: next edge goes to AR2 with remaining=T_AR. Normal sequence resumes from there with GX next.
  - flash_phase clears on FLASH exit.
- BCD: cnt_tens and cnt_ones are combinational from remaining (values <= 99).
- Simulation assertions: all T_* parameters in 1..99; CLK_DIV >= 2.
- Reset mid-operation: returns to the reset values on the next edge regardless of state, prescaler or ped_pend.

Decomposition:
- Package traffic_pkg holds:
  - phase state enum (GX, YX, AR1, GY, YY, AR2, FLASH)
  - light encodings L_RED=100, L_YEL=010, L_GRN=001, L_OFF=000
  - function to map phase to duration
- One sub-module, tick_gen: parameter CLK_DIV; ports clk, rst, tick.
- The BCD split stays inline.

Test Plan:
All scenarios use CLK_DIV=4, T_GX=5, T_GY=3, T_YEL=2, T_AR=1, T_PED=2.
- Reset then free-run for 56 clks -> phases GX5, YX2, AR1 1, GY3, YY2, AR2 1 ticks; back to GX with remaining=5 at clk 56; one tick every 4 clks.
- ped_req pulse in GX at remaining=5 -> next edge remaining=2, ped_pend=0; YX entered 2 ticks later.
- ped_req in YX -> ped_pend stays 1 until GY entry; then remaining 3->2 on the next edge. ped_req in GY at remaining=1 -> no change, ped_pend clears.
- flash=1 during GY -> next edge light_x=light_y=000 or 010, toggling each tick, remaining=0. flash=0 -> AR2 (100/100, remaining=1), then GX.
- rst pulse mid-YY with ped_pend=1 -> next edge GX, remaining=5, ped_pend=0, prescaler restarts (first tick 4 clks later).
- BCD check with T_GX=47 -> cnt_tens=4, cnt_ones=7 after reset; 4/6 after the first tick.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding, light patterns and phase helpers for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {GX, YX, AR1, GY, YY, AR2, FLASH} phase_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      GX:      return YX;
      YX:      return AR1;
      AR1:     return GY;
      GY:      return YY;
      YY:      return AR2;
      AR2:     return GX;
      default: return AR2;
    endcase
  endfunction

  function automatic int unsigned phase_dur(input phase_t p, input int unsigned t_gx,
                                            input int unsigned t_gy, input int unsigned t_yel,
                                            input int unsigned t_ar);
    case (p)
      GX:       return t_gx;
      GY:       return t_gy;
      YX, YY:   return t_yel;
      AR1, AR2: return t_ar;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Free-running prescaler: one registered tick pulse every CLK_DIV clocks.
module tick_gen #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road six-phase traffic controller with pedestrian shortening, night flash
// and a binary/BCD countdown for the display block.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned T_GX    = 30,
  parameter int unsigned T_GY    = 15,
  parameter int unsigned T_YEL   = 3,
  parameter int unsigned T_AR    = 1,
  parameter int unsigned T_PED   = 5,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             flash,
  output logic [2:0]       light_x,
  output logic [2:0]       light_y,
  output logic [CNT_W-1:0] remaining,
  output logic [3:0]       cnt_tens,
  output logic [3:0]       cnt_ones,
  output logic             tick,
  output logic             ped_pend
);

  if (T_GX < 1 || T_GX > 99 || T_GY < 1 || T_GY > 99 || T_YEL < 1 || T_YEL > 99 ||
      T_AR < 1 || T_AR > 99 || T_PED < 1 || T_PED > 99 || CLK_DIV < 2 || CNT_W < 7)
  begin : g_param_chk
    $error("traffic_phase_ctrl: T_* must be 1..99, CLK_DIV >= 2, CNT_W >= 7");
  end

  localparam logic [CNT_W-1:0] REM_GX  = CNT_W'(T_GX);
  localparam logic [CNT_W-1:0] REM_AR  = CNT_W'(T_AR);
  localparam logic [CNT_W-1:0] REM_PED = CNT_W'(T_PED);

  phase_t           state, state_nx;
  logic [CNT_W-1:0] rem_nx;
  logic             ped_nx;
  logic             flash_phase, fp_nx;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GX;
      remaining   <= REM_GX;
      ped_pend    <= 1'b0;
      flash_phase <= 1'b0;
    end else begin
      state       <= state_nx;
      remaining   <= rem_nx;
      ped_pend    <= ped_nx;
      flash_phase <= fp_nx;
    end
  end

  // Priority: flash, flash exit, pedestrian shortening (suppresses the tick), tick.
  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    ped_nx   = ped_pend;
    fp_nx    = flash_phase;
    if (flash) begin
      state_nx = FLASH;
      rem_nx   = '0;
      if (state == FLASH && tick) fp_nx = ~flash_phase;
    end else if (state == FLASH) begin
      state_nx = AR2;
      rem_nx   = REM_AR;
      fp_nx    = 1'b0;
    end else if ((state == GX || state == GY) && ped_pend) begin
      if (remaining > REM_PED) rem_nx = REM_PED;
      ped_nx = 1'b0;
    end else if (tick) begin
      if (remaining > CNT_W'(1)) begin
        rem_nx = remaining - CNT_W'(1);
      end else begin
        state_nx = next_phase(state);
        rem_nx   = CNT_W'(phase_dur(next_phase(state), T_GX, T_GY, T_YEL, T_AR));
      end
    end
    if (ped_req) ped_nx = 1'b1;
  end

  always_comb begin
    light_x = L_RED;
    light_y = L_RED;
    case (state)
      GX:      light_x = L_GRN;
      YX:      light_x = L_YEL;
      GY:      light_y = L_GRN;
      YY:      light_y = L_YEL;
      FLASH: begin
        light_x = flash_phase ? L_YEL : L_OFF;
        light_y = flash_phase ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_tens = 4'(remaining / CNT_W'(10));
    cnt_ones = 4'(remaining % CNT_W'(10));
  end

endmodule
